// File: rtl/div_pkg.sv
// Shared encodings and helpers for the RV32M divide sequencing controller.
package div_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  localparam logic [DW_DEF-1:0] MIN_INT = {1'b1, {(DW_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESP   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response handshake between the EX stage (master) and the divide controller (slave).
interface div_ctrl_if
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
);

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_dividend;
  logic [DW-1:0] req_divisor;
  logic [RW-1:0] req_rd;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic [RW-1:0] resp_rd;

  modport master (
    output req_valid, req_op, req_dividend, req_divisor, req_rd, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_rd
  );

  modport slave (
    input  req_valid, req_op, req_dividend, req_divisor, req_rd, resp_ready,
    output req_ready, resp_valid, resp_data, resp_rd
  );

endinterface

// File: rtl/div_special_detect.sv
// Flags the RV32M cases the divider never sees (x/0, MIN/-1) and forms their results.
module div_special_detect #(
  parameter int DW = 32
) (
  input  logic          signed_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          is_zero_o,
  output logic          is_ovf_o,
  output logic [DW-1:0] quot_o,
  output logic [DW-1:0] rem_o
);

  localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  always_comb begin
    is_zero_o = (divisor_i == '0);
    is_ovf_o  = signed_i && (dividend_i == MIN_V) && (divisor_i == '1);
    // Divide-by-zero outranks overflow; both share one result mux.
    if (is_zero_o) begin
      quot_o = '1;
      rem_o  = dividend_i;
    end else begin
      quot_o = dividend_i;
      rem_o  = '0;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Sequences one DIV/DIVU/REM/REMU at a time onto the shared iterative divider.
// state  | meaning
// IDLE   | ready to accept a request
// RESP   | result presented to writeback
// LAUNCH | single-cycle div_en pulse
// WAIT   | divider running, response owed
// DRAIN  | divider running after flush, result only refreshes the cache
module div_ctrl
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  div_ctrl_if.slave     bus,
  input  logic          flush,
  output logic          busy_o,
  output logic          div_en_o,
  output logic          div_signed_o,
  output logic [DW-1:0] div_dividend_o,
  output logic [DW-1:0] div_divisor_o,
  input  logic [DW-1:0] div_quot_i,
  input  logic [DW-1:0] div_rem_i,
  input  logic          div_done_i
);

  div_state_e    state_q, state_d;
  logic          rdy_en_q, rdy_en_d;
  logic          rem_sel_q, rem_sel_d;
  logic          signed_q, signed_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [DW-1:0] dividend_q, dividend_d;
  logic [DW-1:0] divisor_q, divisor_d;
  logic [DW-1:0] resp_data_q, resp_data_d;

  logic          cache_vld_q, cache_vld_d;
  logic          cache_signed_q, cache_signed_d;
  logic [DW-1:0] cache_dividend_q, cache_dividend_d;
  logic [DW-1:0] cache_divisor_q, cache_divisor_d;
  logic [DW-1:0] cache_quot_q, cache_quot_d;
  logic [DW-1:0] cache_rem_q, cache_rem_d;

  logic          req_signed;
  logic          accept;
  logic          cache_hit;
  logic          cache_load;
  logic          sp_zero, sp_ovf;
  logic [DW-1:0] sp_quot, sp_rem;

  assign req_signed = op_is_signed(bus.req_op);

  div_special_detect #(.DW(DW)) u_special (
    .signed_i   (req_signed),
    .dividend_i (bus.req_dividend),
    .divisor_i  (bus.req_divisor),
    .is_zero_o  (sp_zero),
    .is_ovf_o   (sp_ovf),
    .quot_o     (sp_quot),
    .rem_o      (sp_rem)
  );

  // rdy_en_q keeps req_ready low while reset is asserted.
  assign bus.req_ready = (state_q == ST_IDLE) && rdy_en_q && !flush;
  assign accept        = bus.req_ready && bus.req_valid;
  assign cache_hit     = cache_vld_q && (cache_signed_q == req_signed) &&
                         (cache_dividend_q == bus.req_dividend) &&
                         (cache_divisor_q == bus.req_divisor);

  always_comb begin
    state_d          = state_q;
    rdy_en_d         = 1'b1;
    rem_sel_d        = rem_sel_q;
    signed_d         = signed_q;
    rd_d             = rd_q;
    dividend_d       = dividend_q;
    divisor_d        = divisor_q;
    resp_data_d      = resp_data_q;
    cache_vld_d      = cache_vld_q;
    cache_signed_d   = cache_signed_q;
    cache_dividend_d = cache_dividend_q;
    cache_divisor_d  = cache_divisor_q;
    cache_quot_d     = cache_quot_q;
    cache_rem_d      = cache_rem_q;
    cache_load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rem_sel_d  = op_is_rem(bus.req_op);
          signed_d   = req_signed;
          rd_d       = bus.req_rd;
          dividend_d = bus.req_dividend;
          divisor_d  = bus.req_divisor;
          if (sp_zero || sp_ovf) begin
            resp_data_d = op_is_rem(bus.req_op) ? sp_rem : sp_quot;
            state_d     = ST_RESP;
          end else if (cache_hit) begin
            resp_data_d = op_is_rem(bus.req_op) ? cache_rem_q : cache_quot_q;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: state_d = flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (div_done_i) begin
          cache_load = 1'b1;
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            resp_data_d = rem_sel_q ? div_rem_i : div_quot_i;
            state_d     = ST_RESP;
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (div_done_i) begin
          cache_load = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (flush || bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A flushed run still completes, so its result stays worth caching.
    if (cache_load) begin
      cache_vld_d      = 1'b1;
      cache_signed_d   = signed_q;
      cache_dividend_d = dividend_q;
      cache_divisor_d  = divisor_q;
      cache_quot_d     = div_quot_i;
      cache_rem_d      = div_rem_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      rdy_en_q         <= 1'b0;
      rem_sel_q        <= 1'b0;
      signed_q         <= 1'b0;
      rd_q             <= '0;
      dividend_q       <= '0;
      divisor_q        <= '0;
      resp_data_q      <= '0;
      cache_vld_q      <= 1'b0;
      cache_signed_q   <= 1'b0;
      cache_dividend_q <= '0;
      cache_divisor_q  <= '0;
      cache_quot_q     <= '0;
      cache_rem_q      <= '0;
    end else begin
      state_q          <= state_d;
      rdy_en_q         <= rdy_en_d;
      rem_sel_q        <= rem_sel_d;
      signed_q         <= signed_d;
      rd_q             <= rd_d;
      dividend_q       <= dividend_d;
      divisor_q        <= divisor_d;
      resp_data_q      <= resp_data_d;
      cache_vld_q      <= cache_vld_d;
      cache_signed_q   <= cache_signed_d;
      cache_dividend_q <= cache_dividend_d;
      cache_divisor_q  <= cache_divisor_d;
      cache_quot_q     <= cache_quot_d;
      cache_rem_q      <= cache_rem_d;
    end
  end

  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_rd    = rd_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign div_en_o       = (state_q == ST_LAUNCH);
  assign div_signed_o   = signed_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed scenarios plus random traffic against an RV32M reference.
module tb_div_ctrl;
  import div_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush;
  logic          busy, div_en, div_signed, div_done;
  logic [DW-1:0] div_dividend, div_divisor, div_quot, div_rem;

  always #5 clk = ~clk;

  div_ctrl_if #(.DW(DW), .RW(RW)) bus ();

  div_ctrl #(.DW(DW), .RW(RW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .flush          (flush),
    .busy_o         (busy),
    .div_en_o       (div_en),
    .div_signed_o   (div_signed),
    .div_dividend_o (div_dividend),
    .div_divisor_o  (div_divisor),
    .div_quot_i     (div_quot),
    .div_rem_i      (div_rem),
    .div_done_i     (div_done)
  );

  int checks = 0;
  int failures = 0;
  int en_count = 0;
  int exp_launch = 0;

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference cache: operands of the last divider run since reset.
  logic          mc_vld;
  logic          mc_sgn;
  logic [DW-1:0] mc_a, mc_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] ref_result(input logic [1:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic          sgn;
    logic [DW-1:0] q, r;
    sgn = ~op[0];
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (sgn && a == MIN_INT && b == '1) begin
      q = a;
      r = '0;
    end else if (sgn) begin
      q = DW'($signed(a) / $signed(b));
      r = DW'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Behavioural iterative divider: random latency, spurious done pulses while idle.
  logic          dv_busy;
  int            dv_cnt;
  logic          dv_sgn;
  logic [DW-1:0] dv_a, dv_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_busy  <= 1'b0;
      dv_cnt   <= 0;
      dv_sgn   <= 1'b0;
      dv_a     <= '0;
      dv_b     <= '0;
      div_done <= 1'b0;
      div_quot <= '0;
      div_rem  <= '0;
    end else begin
      div_done <= 1'b0;
      if (dv_busy) begin
        if (dv_cnt == 1) begin
          div_done <= 1'b1;
          dv_busy  <= 1'b0;
          if (dv_sgn) begin
            div_quot <= DW'($signed(dv_a) / $signed(dv_b));
            div_rem  <= DW'($signed(dv_a) % $signed(dv_b));
          end else begin
            div_quot <= dv_a / dv_b;
            div_rem  <= dv_a % dv_b;
          end
        end else begin
          dv_cnt <= dv_cnt - 1;
        end
      end else if (div_en) begin
        dv_busy <= 1'b1;
        dv_cnt  <= int'($urandom_range(2, 6));
        dv_a    <= div_dividend;
        dv_b    <= div_divisor;
        dv_sgn  <= div_signed;
      end else if ($urandom_range(0, 7) == 0) begin
        div_done <= 1'b1;
        div_quot <= $urandom;
        div_rem  <= $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted response.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (div_en) en_count++;
      if (bus.resp_valid && bus.resp_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_resp", 64'(bus.resp_data), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 64'(bus.resp_data), 64'(e.data));
          chk("sb_rd", 64'(bus.resp_rd), 64'(e.rd));
        end
      end
    end
  end

  task automatic chk_reset_zero(input string tag);
    chk({tag, "_ctrl_flags"},
        64'({bus.req_ready, bus.resp_valid, busy, div_en, div_signed}), 64'(0));
    chk({tag, "_resp_data"}, 64'(bus.resp_data), 64'(0));
    chk({tag, "_resp_rd"}, 64'(bus.resp_rd), 64'(0));
    chk({tag, "_div_operands"}, {div_dividend, div_divisor}, 64'(0));
  endtask

  // flush_k > 0: hold resp_ready low and pulse flush k cycles after accept (response dropped).
  // hold_k >= 0: keep resp_ready low for hold_k cycles of resp_valid; hold_k < 0: random.
  task automatic run_req(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [RW-1:0] rd, input int flush_k, input int hold_k,
                         input string tag);
    logic          sgn, special, hit, launch, acc, ok, bad;
    logic [DW-1:0] exp_data;
    int            en0, low;
    exp_t          e;
    sgn      = ~op[0];
    special  = (b == 0) || (sgn && a == MIN_INT && b == '1);
    hit      = !special && mc_vld && mc_sgn == sgn && mc_a == a && mc_b == b;
    launch   = !special && !hit;
    exp_data = ref_result(op, a, b);

    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    bus.req_rd       = rd;
    bus.resp_ready   = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.req_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_accept_timeout"}, 64'(acc), 64'(1));
    if (!acc) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    en0 = en_count;
    if (flush_k == 0) begin
      e.rd   = rd;
      e.data = exp_data;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (launch) chk({tag, "_launch_pulse"}, 64'(div_en), 64'(1));
    else chk({tag, "_latency1"}, 64'(bus.resp_valid), 64'(1));

    if (flush_k > 0) begin
      for (int k = 1; k < flush_k; k++) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      ok  = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (bus.resp_valid) bad = 1'b1;
        if (!busy) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk({tag, "_flush_idle_timeout"}, 64'(ok), 64'(1));
      chk({tag, "_flush_no_resp"}, 64'(bad), 64'(0));
      chk({tag, "_idle_with_divider_running"}, 64'(dv_busy), 64'(0));
    end else begin
      ok  = 1'b0;
      bad = 1'b0;
      low = 0;
      for (int i = 0; i < 200; i++) begin
        if (bus.resp_valid) begin
          if (bus.resp_data !== exp_data || bus.resp_rd !== rd) bad = 1'b1;
          bus.resp_ready = (hold_k < 0) ? 1'($urandom_range(0, 1)) : (low >= hold_k);
          low++;
          if (bus.resp_ready) begin
            @(negedge clk);
            ok = 1'b1;
            break;
          end
        end else begin
          bus.resp_ready = (hold_k < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge clk);
      end
      bus.resp_ready = 1'b0;
      chk({tag, "_resp_timeout"}, 64'(ok), 64'(1));
      chk({tag, "_resp_stable"}, 64'(bad), 64'(0));
      if (ok) chk({tag, "_idle_after_resp"}, 64'({busy, bus.resp_valid}), 64'(0));
    end

    if (launch) begin
      mc_vld = 1'b1;
      mc_sgn = sgn;
      mc_a   = a;
      mc_b   = b;
      exp_launch++;
    end
    chk({tag, "_launch_count"}, 64'(en_count - en0), 64'(launch));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic          acc;
    logic [DW-1:0] pa, pb, ra, rb;
    logic [1:0]    rop;
    int            m, fk;

    flush            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_op       = 2'b00;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.req_rd       = '0;
    bus.resp_ready   = 1'b0;
    mc_vld = 1'b0;
    mc_sgn = 1'b0;
    mc_a   = '0;
    mc_b   = '0;

    repeat (2) @(negedge clk);
    chk_reset_zero("reset");
    rst_n = 1'b1;

    run_req(OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd1, 0, 0, "t1_div");
    run_req(OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd2, 0, 0, "t1_rem_hit");
    run_req(OP_DIVU, 32'h8000_0000, 32'd0, 5'd3, 0, 0, "t2_divu_zero");
    run_req(OP_REMU, 32'h8000_0000, 32'd0, 5'd4, 0, 0, "t2_remu_zero");
    run_req(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 0, 0, "t3_div_ovf");
    run_req(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0, 0, "t3_rem_ovf");
    run_req(OP_DIVU, 32'd1000, 32'd7, 5'd7, 2, 0, "t4_flush_wait");
    run_req(OP_REMU, 32'd1000, 32'd7, 5'd8, 0, 0, "t4_remu_hit");
    run_req(OP_DIVU, 32'd50, 32'd5, 5'd9, 0, 3, "t5_hold");

    // Asynchronous reset while the divider is running.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_op       = OP_DIVU;
    bus.req_dividend = 32'd1234;
    bus.req_divisor  = 32'd7;
    bus.req_rd       = 5'd10;
    acc = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.req_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("t6_accept_timeout", 64'(acc), 64'(1));
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t6_busy_in_wait", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_zero("t6_async_reset");
    exp_launch++;
    mc_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_req(OP_DIVU, 32'd1234, 32'd7, 5'd10, 0, 0, "t6_relaunch");

    pa = 32'd1;
    pb = 32'd1;
    for (int t = 0; t < 150; t++) begin
      m   = int'($urandom_range(0, 9));
      rop = 2'($urandom);
      case (m)
        0: begin ra = $urandom; rb = '0; end
        1: begin ra = MIN_INT; rb = '1; end
        2, 3: begin ra = pa; rb = pb; end
        4: begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 20); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      fk = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 5)) : 0;
      run_req(rop, ra, rb, 5'($urandom), fk, -1, "rnd");
      pa = ra;
      pb = rb;
    end

    repeat (3) @(negedge clk);
    chk("total_launches", 64'(en_count), 64'(exp_launch));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
